// File: rtl/sm_hex_scan_pkg.sv
// ============================================================================
// Module  : sm_hex_scan_pkg
// Purpose : Shared segment glyph constants and types for the hex scan driver.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sm_hex_scan_pkg;

    // Segment vectors are {g,f,e,d,c,b,a}; a 0 bit lights the segment.
    typedef logic [6:0] seg_t;

    localparam seg_t c_SEG_BLANK = 7'h7F;

    localparam seg_t c_SEG_0 = 7'h40;
    localparam seg_t c_SEG_1 = 7'h79;
    localparam seg_t c_SEG_2 = 7'h24;
    localparam seg_t c_SEG_3 = 7'h30;
    localparam seg_t c_SEG_4 = 7'h19;
    localparam seg_t c_SEG_5 = 7'h12;
    localparam seg_t c_SEG_6 = 7'h02;
    localparam seg_t c_SEG_7 = 7'h78;
    localparam seg_t c_SEG_8 = 7'h00;
    localparam seg_t c_SEG_9 = 7'h10;
    localparam seg_t c_SEG_A = 7'h08;
    localparam seg_t c_SEG_B = 7'h03;
    localparam seg_t c_SEG_C = 7'h46;
    localparam seg_t c_SEG_D = 7'h21;
    localparam seg_t c_SEG_E = 7'h06;
    localparam seg_t c_SEG_F = 7'h0E;

endpackage

`default_nettype wire

// File: rtl/sm_hex_display.sv
// ============================================================================
// Module  : sm_hex_display
// Purpose : Combinational nibble to active-low seven-segment glyph decoder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sm_hex_display
    import sm_hex_scan_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = c_SEG_BLANK;
        case (i_nibble)
            4'h0:    o_seg = c_SEG_0;
            4'h1:    o_seg = c_SEG_1;
            4'h2:    o_seg = c_SEG_2;
            4'h3:    o_seg = c_SEG_3;
            4'h4:    o_seg = c_SEG_4;
            4'h5:    o_seg = c_SEG_5;
            4'h6:    o_seg = c_SEG_6;
            4'h7:    o_seg = c_SEG_7;
            4'h8:    o_seg = c_SEG_8;
            4'h9:    o_seg = c_SEG_9;
            4'hA:    o_seg = c_SEG_A;
            4'hB:    o_seg = c_SEG_B;
            4'hC:    o_seg = c_SEG_C;
            4'hD:    o_seg = c_SEG_D;
            4'hE:    o_seg = c_SEG_E;
            default: o_seg = c_SEG_F;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/sm_hex_scan.sv
// ============================================================================
// Module  : sm_hex_scan
// Purpose : Time-multiplexed N-digit seven-segment driver with blanking/blink.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sm_hex_scan
    import sm_hex_scan_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 16,
    parameter int BLINK_DIV = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   valueIn,
    input  logic                  valueLoad,
    input  logic [DIGITS-1:0]     dpIn,
    input  logic                  blankZeros,
    input  logic [DIGITS-1:0]     blinkMask,
    output logic [6:0]            segOut,
    output logic                  dpOut,
    output logic [DIGITS-1:0]     digitSel,
    output logic                  frameTick
);

    localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DIGITS - 1);

    logic [4*DIGITS-1:0] r_value_q, w_value_d;
    logic [DIGITS-1:0]   r_dp_q,    w_dp_d;
    logic [SCAN_DIV-1:0] r_presc_q, w_presc_d;
    logic [c_IDX_W-1:0]  r_idx_q,   w_idx_d;
    logic [BLINK_DIV-1:0] r_blink_q, w_blink_d;
    logic [6:0]          r_seg_q,   w_seg_d;
    logic                r_dpo_q,   w_dpo_d;
    logic [DIGITS-1:0]   r_sel_q,   w_sel_d;
    logic                r_frame_q, w_frame_d;

    logic                w_scan_tick;
    logic                w_wrap;
    logic [DIGITS-1:0]   w_upper_zero;
    logic [3:0]          w_nibble;
    logic                w_dp_req;
    logic                w_blink_req;
    logic                w_lead_zero;
    logic                w_blank;
    logic [6:0]          w_glyph;

    sm_hex_display u_decode (
        .i_nibble (w_nibble),
        .o_seg    (w_glyph)
    );

    always_comb begin
        w_scan_tick = &r_presc_q;
        w_wrap      = w_scan_tick && (r_idx_q == c_IDX_LAST);

        w_presc_d = r_presc_q + SCAN_DIV'(1);

        w_idx_d = r_idx_q;
        if (w_scan_tick) begin
            w_idx_d = w_wrap ? '0 : r_idx_q + c_IDX_W'(1);
        end

        w_blink_d = r_blink_q;
        if (w_wrap) begin
            w_blink_d = r_blink_q + BLINK_DIV'(1);
        end

        w_value_d = r_value_q;
        w_dp_d    = r_dp_q;
        if (valueLoad) begin
            w_value_d = valueIn;
            w_dp_d    = dpIn;
        end
    end

    // w_upper_zero[i] is set when nibbles i..DIGITS-1 of the held value are all zero.
    always_comb begin
        logic v_run;
        v_run        = 1'b1;
        w_upper_zero = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            v_run           = v_run && (r_value_q[4*i +: 4] == 4'h0);
            w_upper_zero[i] = v_run;
        end
    end

    always_comb begin
        w_nibble    = 4'h0;
        w_dp_req    = 1'b0;
        w_blink_req = 1'b0;
        w_lead_zero = 1'b0;
        w_sel_d     = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx_q == c_IDX_W'(i)) begin
                w_nibble    = r_value_q[4*i +: 4];
                w_dp_req    = r_dp_q[i];
                w_blink_req = blinkMask[i];
                w_lead_zero = (i > 0) && w_upper_zero[i];
                w_sel_d[i]  = 1'b0;
            end
        end

        w_blank   = (blankZeros && w_lead_zero) ||
                    (w_blink_req && r_blink_q[BLINK_DIV-1]);
        w_seg_d   = w_blank ? c_SEG_BLANK : w_glyph;
        w_dpo_d   = w_blank ? 1'b1 : ~w_dp_req;
        w_frame_d = w_wrap;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_value_q <= '0;
            r_dp_q    <= '0;
            r_presc_q <= '0;
            r_idx_q   <= '0;
            r_blink_q <= '0;
            r_seg_q   <= c_SEG_BLANK;
            r_dpo_q   <= 1'b1;
            r_sel_q   <= '1;
            r_frame_q <= 1'b0;
        end else begin
            r_value_q <= w_value_d;
            r_dp_q    <= w_dp_d;
            r_presc_q <= w_presc_d;
            r_idx_q   <= w_idx_d;
            r_blink_q <= w_blink_d;
            r_seg_q   <= w_seg_d;
            r_dpo_q   <= w_dpo_d;
            r_sel_q   <= w_sel_d;
            r_frame_q <= w_frame_d;
        end
    end

    assign segOut    = r_seg_q;
    assign dpOut     = r_dpo_q;
    assign digitSel  = r_sel_q;
    assign frameTick = r_frame_q;

endmodule

`default_nettype wire

// File: tb/tb_sm_hex_scan.sv
// ============================================================================
// Module  : tb_sm_hex_scan
// Purpose : Self-checking bench for sm_hex_scan (4-digit and 1-digit builds).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sm_hex_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        valueLoad;
    logic        blankZeros;
    logic [15:0] valueIn;
    logic [3:0]  dpIn;
    logic [3:0]  blinkMask;

    logic [6:0]  seg4;
    logic        dp4;
    logic [3:0]  sel4;
    logic        ft4;
    logic [6:0]  seg1;
    logic        dp1;
    logic [0:0]  sel1;
    logic        ft1;

    int checks   = 0;
    int failures = 0;

    // Model state: edges since reset, held value and decimal points.
    int          m_n     = 0;
    logic [15:0] m_val   = '0;
    logic [3:0]  m_dp    = '0;

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    always #5 clk = ~clk;

    sm_hex_scan #(.DIGITS(4), .SCAN_DIV(2), .BLINK_DIV(1)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .valueIn    (valueIn),
        .valueLoad  (valueLoad),
        .dpIn       (dpIn),
        .blankZeros (blankZeros),
        .blinkMask  (blinkMask),
        .segOut     (seg4),
        .dpOut      (dp4),
        .digitSel   (sel4),
        .frameTick  (ft4)
    );

    sm_hex_scan #(.DIGITS(1), .SCAN_DIV(2), .BLINK_DIV(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .valueIn    (valueIn[3:0]),
        .valueLoad  (valueLoad),
        .dpIn       (dpIn[0:0]),
        .blankZeros (blankZeros),
        .blinkMask  (blinkMask[0:0]),
        .segOut     (seg1),
        .dpOut      (dp1),
        .digitSel   (sel1),
        .frameTick  (ft1)
    );

    // Expected pins after the next edge, given n edges of free running since reset.
    // Packed as {frame, sel[7:0], dp, seg[6:0]}.
    function automatic logic [16:0] model_out(int d, int n, logic [31:0] val,
                                              logic [7:0] dp, logic bz, logic [7:0] bm);
        int         i;
        int         frames;
        logic       phase;
        logic       lead;
        logic       blank;
        logic [6:0] seg;
        logic       dpo;
        logic [7:0] sel;
        logic       frame;
        i      = (n / 4) % d;
        frames = n / (4 * d);
        phase  = (frames % 2) == 1;
        lead   = bz && (i > 0) && ((val >> (4 * i)) == 0);
        blank  = lead || (bm[i] && phase);
        seg    = blank ? 7'h7F : glyph[(val >> (4 * i)) & 32'hF];
        dpo    = blank ? 1'b1 : ~dp[i];
        sel    = ~(8'd1 << i) & 8'((1 << d) - 1);
        frame  = ((n + 1) % (4 * d)) == 0;
        return {frame, sel, dpo, seg};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (n=%0d)", tag, obs, exp, m_n);
        end
    endtask

    task automatic tick();
        logic [16:0] e4;
        logic [16:0] e1;
        logic        r;
        r = rst;
        if (r) begin
            e4 = {1'b0, 8'h0F, 1'b1, 7'h7F};
            e1 = {1'b0, 8'h01, 1'b1, 7'h7F};
            m_n   = 0;
            m_val = '0;
            m_dp  = '0;
        end else begin
            e4 = model_out(4, m_n, {16'h0, m_val}, {4'h0, m_dp}, blankZeros, {4'h0, blinkMask});
            e1 = model_out(1, m_n, {28'h0, m_val[3:0]}, {7'h0, m_dp[0]}, blankZeros,
                           {7'h0, blinkMask[0]});
            m_n++;
            if (valueLoad) begin
                m_val = valueIn;
                m_dp  = dpIn;
            end
        end
        @(posedge clk);
        #1;
        chk("seg4",   seg4, e4[6:0]);
        chk("dp4",    dp4,  e4[7]);
        chk("sel4",   sel4, e4[11:8]);
        chk("frame4", ft4,  e4[16]);
        chk("seg1",   seg1, e1[6:0]);
        chk("dp1",    dp1,  e1[7]);
        chk("sel1",   sel1, e1[8]);
        chk("frame1", ft1,  e1[16]);
    endtask

    task automatic load(logic [15:0] v, logic [3:0] d);
        valueIn   = v;
        dpIn      = d;
        valueLoad = 1'b1;
        tick();
        valueLoad = 1'b0;
    endtask

    task automatic run(int cycles);
        for (int k = 0; k < cycles; k++) tick();
    endtask

    initial begin
        rst        = 1'b1;
        valueLoad  = 1'b0;
        blankZeros = 1'b0;
        valueIn    = '0;
        dpIn       = '0;
        blinkMask  = '0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;

        // Plain scan of the reset value.
        run(40);

        // Mixed glyphs with one decimal point.
        load(16'h1A2F, 4'b0100);
        run(40);

        // Leading-zero suppression.
        blankZeros = 1'b1;
        load(16'h0007, 4'b0000);
        run(20);
        load(16'h0000, 4'b1111);
        run(20);
        blankZeros = 1'b0;
        run(20);

        // Blinking digit 0.
        blinkMask = 4'b0001;
        load(16'h1111, 4'b0000);
        run(64);
        blinkMask = 4'b0000;

        // Load coinciding with a digit step.
        for (int k = 0; k < 8 && (m_n % 4) != 3; k++) tick();
        load(16'hBEEF, 4'b1010);
        run(20);

        // Reset while digit 2 is being driven.
        for (int k = 0; k < 20 && ((m_n / 4) % 4) != 2; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run(20);

        // Randomised traffic.
        for (int k = 0; k < 600; k++) begin
            valueLoad = ($urandom_range(0, 7) == 0);
            valueIn   = 16'($urandom >> $urandom_range(16, 31));
            dpIn      = 4'($urandom);
            if ((k % 50) == 0) begin
                blankZeros = 1'($urandom);
                blinkMask  = 4'($urandom);
            end
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst       = 1'b0;
        valueLoad = 1'b0;
        run(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
